// File: rtl/eth_rx_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_cmd_seq_pkg
// Description : Shared constants, state encoding and helpers for the
//               Ethernet receive-buffer command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_cmd_seq_pkg;

    // Command packet identification
    localparam logic [7:0] MAGIC       = 8'hA5;
    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam int         MAX_WRITES  = 20;
    localparam int         SYNC_STAGES = 2;

    // Packet geometry (byte offsets inside the receive RAM)
    localparam int HDR_LEN    = 3;
    localparam int TRIPLE_LEN = 3;
    localparam int PKT_BYTES  = 64;
    localparam int RAM_AW     = $clog2(PKT_BYTES);

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        FETCH   = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_cmd_seq_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : N-stage flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous level in at the low end of the chain
    generate
        if (STAGES == 1) begin : g_single
            always_comb sync_d = i_async;
        end else begin : g_chain
            always_comb sync_d = {sync_q[STAGES-2:0], i_async};
        end
    endgenerate

    // Synchronizer flops, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign o_sync = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/eth_rx_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_cmd_seq
// Description : Drains the Ethernet receive packet RAM, parses it as a
//               register-write list and issues the writes on the config bus,
//               then hands the buffer back to the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_cmd_seq
    import eth_rx_cmd_seq_pkg::*;
(
    input  logic               clk_cpu,
    input  logic               clk_cpu_reset,
    input  logic               eth_rx_ready,
    output logic               eth_rx_read,
    output logic [RAM_AW-1:0]  ram_addr,
    input  logic [7:0]         ram_rdata,
    output logic [7:0]         cfg_addr,
    output logic [15:0]        cfg_wdata,
    output logic               cfg_we,
    input  logic               cfg_busy,
    output logic [15:0]        pkt_count,
    output logic [15:0]        err_count,
    output logic               busy
);

    logic              rdy_s;
    state_e            state_q,     state_d;
    logic [1:0]        ph_q,        ph_d;        // cycle within HDR/FETCH, min-hold in RELEASE
    logic [RAM_AW-1:0] ram_addr_q,  ram_addr_d;
    logic [7:0]        byte0_q,     byte0_d;
    logic [7:0]        opcode_q,    opcode_d;
    logic [7:0]        n_q,         n_d;
    logic [7:0]        k_q,         k_d;
    logic [7:0]        cfg_addr_q,  cfg_addr_d;
    logic [15:0]       cfg_wdata_q, cfg_wdata_d;
    logic [15:0]       pkt_cnt_q,   pkt_cnt_d;
    logic [15:0]       err_cnt_q,   err_cnt_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .clk     (clk_cpu),
        .rst     (clk_cpu_reset),
        .i_async (eth_rx_ready),
        .o_sync  (rdy_s)
    );

    // State and datapath registers
    always_ff @(posedge clk_cpu) begin
        if (clk_cpu_reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            ram_addr_q  <= '0;
            byte0_q     <= '0;
            opcode_q    <= '0;
            n_q         <= '0;
            k_q         <= '0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            ram_addr_q  <= ram_addr_d;
            byte0_q     <= byte0_d;
            opcode_q    <= opcode_d;
            n_q         <= n_d;
            k_q         <= k_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next state plus RAM address walk, byte capture and counters.
    // In HDR/FETCH the address advances on phases 0..2 so each read issues
    // back-to-back; phases 1..3 see the data of the previous phase's address.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        ram_addr_d  = ram_addr_q;
        byte0_d     = byte0_q;
        opcode_d    = opcode_q;
        n_d         = n_q;
        k_d         = k_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                ram_addr_d = '0;
                ph_d       = '0;
                if (rdy_s) state_d = HDR;
            end
            HDR: begin
                ph_d = ph_q + 2'd1;
                if (ph_q != 2'd3) ram_addr_d = ram_addr_q + 1'b1;
                if (ph_q == 2'd1) byte0_d  = ram_rdata;
                if (ph_q == 2'd2) opcode_d = ram_rdata;
                if (ph_q == 2'd3) begin
                    ph_d = '0;
                    n_d  = ram_rdata;
                    k_d  = '0;
                    if ((byte0_q != MAGIC) || (opcode_q != OP_WRITE) ||
                        (ram_rdata > 8'(MAX_WRITES))) begin
                        err_cnt_d = sat_inc16(err_cnt_q);
                        state_d   = RELEASE;
                    end else if (ram_rdata == 8'd0) begin
                        pkt_cnt_d = sat_inc16(pkt_cnt_q);
                        state_d   = RELEASE;
                    end else begin
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                ph_d = ph_q + 2'd1;
                if (ph_q != 2'd3) ram_addr_d = ram_addr_q + 1'b1;
                if (ph_q == 2'd1) cfg_addr_d         = ram_rdata;
                if (ph_q == 2'd2) cfg_wdata_d[15:8]  = ram_rdata;
                if (ph_q == 2'd3) begin
                    cfg_wdata_d[7:0] = ram_rdata;
                    ph_d             = '0;
                    state_d          = WRITE;
                end
            end
            WRITE: begin
                ph_d = '0;
                if (!cfg_busy) begin
                    k_d = k_q + 8'd1;
                    if ((k_q + 8'd1) == n_q) begin
                        pkt_cnt_d = sat_inc16(pkt_cnt_q);
                        state_d   = RELEASE;
                    end else begin
                        state_d   = FETCH;
                    end
                end
            end
            RELEASE: begin
                // Guarantee at least two cycles of eth_rx_read
                ph_d = 2'd1;
                if ((ph_q != 2'd0) && !rdy_s) begin
                    ph_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        busy        = (state_q != IDLE);
        cfg_we      = (state_q == WRITE);
        eth_rx_read = (state_q == RELEASE);
        ram_addr    = ram_addr_q;
        cfg_addr    = cfg_addr_q;
        cfg_wdata   = cfg_wdata_q;
        pkt_count   = pkt_cnt_q;
        err_count   = err_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_cmd_seq
// Description : Self-checking bench for eth_rx_cmd_seq with a packet RAM
//               model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_cmd_seq;

    localparam int C_SYNC = 2;

    logic        clk_cpu = 1'b0;
    logic        clk_cpu_reset;
    logic        eth_rx_ready;
    logic        eth_rx_read;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_we;
    logic        cfg_busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        busy;

    logic [7:0]  mem [64];
    logic [23:0] exp_q [$];
    int          vectors     = 0;
    int          miscompares = 0;

    eth_rx_cmd_seq dut (
        .clk_cpu       (clk_cpu),
        .clk_cpu_reset (clk_cpu_reset),
        .eth_rx_ready  (eth_rx_ready),
        .eth_rx_read   (eth_rx_read),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_we        (cfg_we),
        .cfg_busy      (cfg_busy),
        .pkt_count     (pkt_count),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Synchronous-read packet RAM: data one cycle after the address
    always @(posedge clk_cpu) ram_rdata <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every accepted write must match the head of the queue
    always @(negedge clk_cpu) begin
        #1;
        if (!clk_cpu_reset && cfg_we && !cfg_busy) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("write_addr_data", {8'h00, cfg_addr, cfg_wdata}, {8'h00, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input logic [7:0] b0, input logic [7:0] op, input logic [7:0] n);
        for (int i = 3; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = b0;
        mem[1] = op;
        mem[2] = n;
    endtask

    task automatic push_writes(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({mem[3+3*k], mem[4+3*k], mem[5+3*k]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {29'd0, busy, eth_rx_read, cfg_we}, 32'd0);
        check({tag, "_ram_addr"}, {26'd0, ram_addr}, 32'd0);
        check({tag, "_cfg"}, {8'd0, cfg_addr, cfg_wdata}, 32'd0);
        check({tag, "_counts"}, {pkt_count, err_count}, 32'd0);
    endtask

    // Wait for release, hold ready a few cycles, drop it and check the return to idle
    task automatic finish_pkt(input logic [15:0] exp_pkt, input logic [15:0] exp_err);
        int t;
        t = 0;
        while (!eth_rx_read && t < 300) begin
            @(negedge clk_cpu);
            t++;
        end
        check("read_asserted", {31'd0, eth_rx_read}, 32'd1);
        repeat (3) @(negedge clk_cpu);
        check("read_level_held", {31'd0, eth_rx_read}, 32'd1);
        check("writes_outstanding", exp_q.size(), 32'd0);
        eth_rx_ready = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk_cpu);
            t++;
        end
        check("released_idle", {30'd0, busy, eth_rx_read}, 32'd0);
        check("pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkt});
        check("err_count", {16'd0, err_count}, {16'd0, exp_err});
        @(negedge clk_cpu);
    endtask

    initial begin
        int t;
        clk_cpu_reset = 1'b1;
        eth_rx_ready  = 1'b0;
        cfg_busy      = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk_cpu);
        check_reset_outputs("reset");
        clk_cpu_reset = 1'b0;
        repeat (2) @(negedge clk_cpu);

        // Valid two-write packet with latency check
        load_pkt(8'hA5, 8'h01, 8'h02);
        mem[3] = 8'h10; mem[4] = 8'h12; mem[5] = 8'h34;
        mem[6] = 8'h11; mem[7] = 8'hAB; mem[8] = 8'hCD;
        push_writes(2);
        eth_rx_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk_cpu);
            t++;
        end while (!cfg_we && t < 40);
        check("first_we_latency", t, C_SYNC + 9);
        finish_pkt(16'd1, 16'd0);

        // Bad magic
        load_pkt(8'h5A, 8'h01, 8'h01);
        eth_rx_ready = 1'b1;
        finish_pkt(16'd1, 16'd1);

        // Too many writes
        load_pkt(8'hA5, 8'h01, 8'd21);
        eth_rx_ready = 1'b1;
        finish_pkt(16'd1, 16'd2);

        // Unknown opcode
        load_pkt(8'hA5, 8'h02, 8'h01);
        eth_rx_ready = 1'b1;
        finish_pkt(16'd1, 16'd3);

        // Maximum-length list, last triple at bytes 60..62
        load_pkt(8'hA5, 8'h01, 8'd20);
        push_writes(20);
        eth_rx_ready = 1'b1;
        finish_pkt(16'd2, 16'd3);

        // Empty list
        load_pkt(8'hA5, 8'h01, 8'd0);
        eth_rx_ready = 1'b1;
        finish_pkt(16'd3, 16'd3);

        // Config bus stall on the first write
        load_pkt(8'hA5, 8'h01, 8'd3);
        push_writes(3);
        cfg_busy     = 1'b1;
        eth_rx_ready = 1'b1;
        t = 0;
        while (!cfg_we && t < 40) begin
            @(negedge clk_cpu);
            t++;
        end
        for (int i = 0; i < 7; i++) begin
            check("stall_hold", {7'd0, cfg_we, cfg_addr, cfg_wdata}, {8'h01, exp_q[0]});
            if (i < 6) @(negedge clk_cpu);
        end
        cfg_busy = 1'b0;
        finish_pkt(16'd4, 16'd3);

        // Reset while a write of a five-write packet is pending
        load_pkt(8'hA5, 8'h01, 8'd5);
        push_writes(5);
        eth_rx_ready = 1'b1;
        t = 0;
        while (exp_q.size() > 3 && t < 100) begin
            @(negedge clk_cpu);
            t++;
        end
        check("two_writes_before_reset", exp_q.size(), 32'd3);
        cfg_busy = 1'b1;
        t = 0;
        while (!cfg_we && t < 20) begin
            @(negedge clk_cpu);
            t++;
        end
        check("write_pending_at_reset", {31'd0, cfg_we}, 32'd1);
        clk_cpu_reset = 1'b1;
        @(negedge clk_cpu);
        check_reset_outputs("midop_reset");
        clk_cpu_reset = 1'b0;
        exp_q.delete();
        push_writes(5);
        cfg_busy = 1'b0;
        finish_pkt(16'd1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_cmd_seq.md
Name: eth_rx_cmd_seq

Overview:
- CPU-domain controller that drains the 64-byte Ethernet receive packet RAM.
- Parses the payload as a register-write command list and issues the writes on the 8-bit-address / 16-bit-data configuration bus.
- Returns the buffer to the receiver with the ready/read handshake.
- Sits between the receiver's packet RAM read port and the configuration register file.

Parameters:
- MAGIC, 8'hA5, required value of payload byte 0.
- OP_WRITE, 8'h01, opcode for a register-write list.
- MAX_WRITES, 20, maximum write count; 3+3*20 = 63 bytes fits the 64-byte buffer.
- SYNC_STAGES, 2, synchronizer depth for eth_rx_ready.

Ports:
- clk_cpu  in  1  CPU clock; the only clock.
- clk_cpu_reset  in  1  reset, synchronous, active-high.
- eth_rx_ready  in  1  buffer-full flag from the receive clock domain (asynchronous).
- eth_rx_read  out  1  buffer release, level.
- ram_addr  out  6  packet RAM read address.
- ram_rdata  in  8  packet RAM read data; valid one cycle after ram_addr.
- cfg_addr  out  8  configuration register address.
- cfg_wdata  out  16  configuration write data.
- cfg_we  out  1  write strobe; held until accepted.
- cfg_busy  in  1  configuration bus stall.
- pkt_count  out  16  accepted command packets.
- err_count  out  16  rejected packets.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Reset values: state=IDLE; eth_rx_read=0, cfg_we=0, ram_addr=0, cfg_addr=0, cfg_wdata=0, pkt_count=0, err_count=0, busy=0; synchronizer flops cleared.
  - Reset mid-operation aborts immediately: no further cfg_we, eth_rx_read drops. A buffer still full is re-processed after reset.
- eth_rx_ready passes through SYNC_STAGES flops; rdy_s below is the synchronized value.
- Packet layout:
  - byte0 = MAGIC, byte1 = opcode, byte2 = N.
  - Then N triples {addr, data[15:8], data[7:0]} at bytes 3+3k..5+3k.
  - Bytes after the last triple are ignored.
- RAM read timing: ram_addr driven in cycle t; ram_rdata sampled at t+1. Pipelined back-to-back reads are allowed.
- States:
  - IDLE: on rdy_s=1 set ram_addr=0 and go to HDR.
  - HDR: read bytes 0,1,2 (3 issue cycles plus 1 latency). Then:
    - byte0!=MAGIC, or byte1!=OP_WRITE, or N>MAX_WRITES -> err_count++, go to RELEASE. No writes are issued.
    - N=0 -> pkt_count++, go to RELEASE.
    - Otherwise k=0, go to FETCH.
  - FETCH: read the 3 bytes of triple k into the cfg_addr/cfg_wdata holding registers, then go to WRITE.
  - WRITE: assert cfg_we with stable cfg_addr/cfg_wdata.
    - A write is accepted on the first cycle with cfg_we=1 and cfg_busy=0; cfg_we deasserts the next cycle.
    - After acceptance: k++. If k==N then pkt_count++ and go to RELEASE, else go to FETCH.
  - RELEASE: eth_rx_read=1. Hold until rdy_s=0, then eth_rx_read=0 and go to IDLE.
    - The receiver must observe the level, so eth_rx_read is never a single pulse.
- Writes are issued in packet order; exactly N writes per accepted packet.
- Counters are 16-bit and saturate at 16'hFFFF (no wrap).
- rdy_s falling outside RELEASE (receiver glitch or reset) is ignored. Processing completes on the RAM contents.
- Latency with cfg_busy=0, from rdy_s rising to first cfg_we: 1 (IDLE) + 4 (HDR) + 4 (FETCH) = 9 cycles.
- Each subsequent write takes 5 cycles (4 FETCH + 1 WRITE).

Decomposition:
- Shared package: state enum (IDLE, HDR, FETCH, WRITE, RELEASE), MAGIC/OP_WRITE constants, and the packet byte-offset constants (HDR_LEN=3, TRIPLE_LEN=3, PKT_BYTES=64).
- One sub-module, sync_bit: an N-stage flop synchronizer, reusable wherever ready/read cross clock domains.
- The FSM, address counter, triple index and saturating counters stay in eth_rx_cmd_seq.

Test Plan:
- Valid packet {A5,01,02, 10,12,34, 11,AB,CD}, cfg_busy=0:
  - cfg writes (10,1234) then (11,ABCD); first cfg_we 9 cycles after rdy_s.
  - pkt_count=1; eth_rx_read high until ready drops.
- Bad magic {5A,01,01,...}: no cfg_we, err_count=1, pkt_count=0; eth_rx_read still asserted and released normally.
- N=21, and separately opcode 02: no writes, err_count increments each time.
- N=20: 20 writes, the last from bytes 60..62, then release. N=0: zero writes, pkt_count++.
- cfg_busy held high for 7 cycles during write 1: cfg_we stays high with stable addr/data; exactly one write accepted, no duplicates.
- Reset asserted during WRITE of a 5-write packet:
  - All outputs return to reset values the next cycle.
  - With ready still high after reset, the packet is reprocessed from byte 0 and all 5 writes are issued.
